vram_cpu_port: RTL and testbench
================================

VRAM_CPU_PORT -- requirements
Module: vram_cpu_port

Interface
REQ-001 The block SHALL have parameter VRAMMOD_RESET, default 16'h0001, the reset value of the modulo register.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on nLSPWE and nLSPOE (minimum 2).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: CLK_24M in 1, system clock; RESET in 1, asynchronous active-high reset.
REQ-004 The block SHALL have these CPU-side ports: M68K_ADDR in 2, register select (0=VRAMADDR, 1=VRAMRW, 2=VRAMMOD, 3=reserved); M68K_DATA_IN in 16, CPU write data; M68K_DATA_OUT out 16, CPU read data; M68K_DATA_OE out 1, read-drive enable; nLSPWE in 1, asynchronous write strobe, active-low; nLSPOE in 1, asynchronous read strobe, active-low.
REQ-005 The block SHALL have these VRAM-side ports: CPU_SLOT in 1, VRAM access slot granted to the CPU for this cycle; VRAM_ADDR out 16, access address; VRAM_WDATA out 16, write data; VRAM_WE out 1, one-cycle write strobe; VRAM_RE out 1, one-cycle read strobe; VRAM_RDATA in 16, read data valid one cycle after VRAM_RE.
REQ-006 The block SHALL have these status ports: BUSY out 1, an operation or held event is pending; OVERRUN out 1, sticky flag, an event was dropped.

Function
REQ-007 Synchronization SHALL pass nLSPWE and nLSPOE through SYNC_STAGES flops followed by one history flop; each strobe's falling edge is the cycle where the last sync stage is 0 and the history flop is 1.
REQ-008 Sampling SHALL take M68K_ADDR and M68K_DATA_IN on the write-edge cycle to form a write event.
REQ-009 Event handling: event to reg 0 sets ADDR to the data and starts a read; event to reg 1 sets WBUF to the data and starts a write; event to reg 2 sets MOD to the data and completes the same cycle with no VRAM access; event to reg 3 is discarded.
REQ-010 States: IDLE, WR_WAIT, WR_DO, INC, RD_WAIT, RD_DO, RD_CAP.
REQ-011 Transitions from IDLE: a reg 1 event goes to WR_WAIT; a reg 0 event goes to RD_WAIT.
REQ-012 Write path: WR_WAIT goes to WR_DO on CPU_SLOT=1; WR_DO lasts one cycle with VRAM_WE=1, VRAM_ADDR=ADDR and VRAM_WDATA=WBUF, then goes to INC.
REQ-013 Increment: INC sets ADDR[14:0] to ADDR[14:0]+MOD[14:0] modulo 2^15, leaves ADDR[15] unchanged, ignores MOD[15], then goes to RD_WAIT (prefetch).
REQ-014 Read path: RD_WAIT goes to RD_DO on CPU_SLOT=1; RD_DO lasts one cycle with VRAM_RE=1 and VRAM_ADDR=ADDR; RD_CAP loads RBUF from VRAM_RDATA, then returns to IDLE.
REQ-015 CPU_SLOT SHALL be ignored in IDLE, WR_DO, INC, RD_DO and RD_CAP.
REQ-016 VRAM_WE and VRAM_RE SHALL never be asserted together, and each SHALL be asserted for exactly one cycle per access.
REQ-017 BUSY SHALL be 1 in every state except IDLE, and also whenever the hold register is full.
REQ-018 Hold register: one-deep; an event arriving while not IDLE is stored there; a reg 2 event arriving while not IDLE is also deferred.
REQ-019 The held event SHALL be consumed on the first IDLE cycle, exactly as in REQ-009, and takes priority over a same-cycle new event, which is then stored in the hold register.
REQ-020 An event arriving while the hold register is full SHALL be dropped and SHALL set OVERRUN; OVERRUN clears only on RESET.
REQ-021 A read of reg 0 or reg 1 SHALL return RBUF, a read of reg 2 SHALL return MOD, and a read of reg 3 SHALL return 16'h0000.
REQ-022 M68K_DATA_OUT SHALL be a combinational mux on the current M68K_ADDR and SHALL have no side effects.
REQ-023 M68K_DATA_OE SHALL equal the synchronized (~nLSPOE & nLSPWE), delayed SYNC_STAGES cycles.
REQ-024 Latency: a reg 1 event with CPU_SLOT held at 1 yields VRAM_WE 2 cycles after the event cycle, and the refreshed RBUF 6 cycles after the event cycle.

Reset
REQ-025 While RESET=1 the block SHALL hold state=IDLE, ADDR=0, MOD=VRAMMOD_RESET, WBUF=0, RBUF=0, hold register empty, OVERRUN=0, BUSY=0, VRAM_WE=0, VRAM_RE=0, M68K_DATA_OE=0, and all sync and history flops=1.
REQ-026 A RESET asserted mid-operation SHALL abort the operation immediately with no further VRAM strobe, and the first event after release SHALL be treated as fresh.

Verification
REQ-027 Reset scenario: write reg0=16'h8123, reg2=16'h0020, reg1=16'hABCD with CPU_SLOT=1 -> VRAM_WE at VRAM_ADDR 16'h8123 with data 16'hABCD, then ADDR=16'h8143, then VRAM_RE at 16'h8143, and RBUF is updated.
REQ-028 Wrap scenario: ADDR=16'h7FFF, MOD=16'h0002, write reg1 -> ADDR becomes 16'h0001; with ADDR=16'hFFFF it becomes 16'h8001.
REQ-029 Slot-starvation scenario: hold CPU_SLOT=0 for 50 cycles after a reg1 write -> no strobe and BUSY=1 throughout; a single-cycle CPU_SLOT pulse -> exactly one VRAM_WE.
REQ-030 Overrun scenario: three reg1 writes during one pending write with CPU_SLOT=0 -> the second write is held, the third is dropped, OVERRUN=1, and exactly two VRAM_WE occur once slots open.
REQ-031 Reset-abort scenario: assert RESET in WR_WAIT, then release -> no VRAM_WE, all outputs at reset values, and a subsequent reg2 read returns VRAMMOD_RESET.
REQ-032 Read scenario: reg0 write 16'h0100 with VRAM_RDATA=16'h5A5A -> a later read of reg1 returns 16'h5A5A with M68K_DATA_OE=1, and a read of reg3 returns 16'h0000.

Source files
------------

// File: rtl/vram_cpu_port_if.sv
// ---------------------------------------------------------------------------
// vram_cpu_port_if
// Bus bundle between the 68k CPU side, the VRAM arbiter and vram_cpu_port.
//   CPU side : M68K_ADDR (register select), M68K_DATA_IN/OUT, M68K_DATA_OE,
//              nLSPWE / nLSPOE (asynchronous active-low strobes)
//   VRAM side: CPU_SLOT (access slot grant), VRAM_ADDR, VRAM_WDATA,
//              VRAM_WE / VRAM_RE (one-cycle strobes), VRAM_RDATA
//   Status   : BUSY, OVERRUN
// The slave modport is the port block itself; master is its environment.
// ---------------------------------------------------------------------------
interface vram_cpu_port_if;
  logic [1:0]  M68K_ADDR;
  logic [15:0] M68K_DATA_IN;
  logic [15:0] M68K_DATA_OUT;
  logic        M68K_DATA_OE;
  logic        nLSPWE;
  logic        nLSPOE;
  logic        CPU_SLOT;
  logic [15:0] VRAM_ADDR;
  logic [15:0] VRAM_WDATA;
  logic        VRAM_WE;
  logic        VRAM_RE;
  logic [15:0] VRAM_RDATA;
  logic        BUSY;
  logic        OVERRUN;

  modport slave (
    input  M68K_ADDR, M68K_DATA_IN, nLSPWE, nLSPOE, CPU_SLOT, VRAM_RDATA,
    output M68K_DATA_OUT, M68K_DATA_OE, VRAM_ADDR, VRAM_WDATA, VRAM_WE,
           VRAM_RE, BUSY, OVERRUN
  );

  modport master (
    output M68K_ADDR, M68K_DATA_IN, nLSPWE, nLSPOE, CPU_SLOT, VRAM_RDATA,
    input  M68K_DATA_OUT, M68K_DATA_OE, VRAM_ADDR, VRAM_WDATA, VRAM_WE,
           VRAM_RE, BUSY, OVERRUN
  );
endinterface

// File: rtl/vram_cpu_port.sv
// ---------------------------------------------------------------------------
// vram_cpu_port
// CPU access port into video RAM. The CPU writes three registers through
// asynchronous strobes: VRAMADDR (0, sets address and prefetches), VRAMRW
// (1, writes data at the address, then auto-increments by VRAMMOD and
// prefetches the new address) and VRAMMOD (2, increment step). Reads of
// registers 0/1 return the prefetch buffer, register 2 returns the step.
// VRAM accesses are only issued in cycles where the arbiter grants CPU_SLOT.
// Ports:
//   CLK_24M - system clock
//   RESET   - asynchronous active-high reset
//   bus     - CPU / VRAM / status signals (see vram_cpu_port_if)
// Parameters:
//   VRAMMOD_RESET - reset value of the modulo register
//   SYNC_STAGES   - synchronizer depth on nLSPWE / nLSPOE (must be >= 2)
// ---------------------------------------------------------------------------
module vram_cpu_port #(
  parameter logic [15:0] VRAMMOD_RESET = 16'h0001,
  parameter int          SYNC_STAGES   = 2
) (
  input logic            CLK_24M,
  input logic            RESET,
  vram_cpu_port_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    WR_DO   = 3'd2,
    INC     = 3'd3,
    RD_WAIT = 3'd4,
    RD_DO   = 3'd5,
    RD_CAP  = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
  logic [SYNC_STAGES-1:0] oe_sync_q, oe_sync_d;
  logic                   we_hist_q, oe_hist_q;
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            mod_q, mod_d;
  logic [15:0]            wbuf_q, wbuf_d;
  logic [15:0]            rbuf_q, rbuf_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [1:0]             hold_reg_q, hold_reg_d;
  logic [15:0]            hold_data_q, hold_data_d;
  logic                   overrun_q, overrun_d;
  logic                   vram_we_q, vram_re_q, busy_q, data_oe_q;

  logic                   we_fall_s, oe_fall_s, unused_s;
  logic                   ev_take_s;
  logic [1:0]             ev_reg_s;
  logic [15:0]            ev_data_s;
  logic [14:0]            addr_inc_s;
  logic [15:0]            data_out_s;

  // Strobe synchronizers: new sample enters at bit 0, oldest at the top bit.
  always_comb begin
    we_sync_d = {we_sync_q[SYNC_STAGES-2:0], bus.nLSPWE};
    oe_sync_d = {oe_sync_q[SYNC_STAGES-2:0], bus.nLSPOE};
  end

  assign we_fall_s = ~we_sync_q[SYNC_STAGES-1] & we_hist_q;
  // The read strobe edge carries no action: register reads are side-effect free.
  assign oe_fall_s = ~oe_sync_q[SYNC_STAGES-1] & oe_hist_q;
  assign unused_s  = oe_fall_s;

  // Event selection, hold register management and access sequencing.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mod_d       = mod_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    hold_vld_d  = hold_vld_q;
    hold_reg_d  = hold_reg_q;
    hold_data_d = hold_data_q;
    overrun_d   = overrun_q;
    ev_take_s   = 1'b0;
    ev_reg_s    = 2'd0;
    ev_data_s   = 16'd0;
    addr_inc_s  = addr_q[14:0] + mod_q[14:0];

    // In IDLE the held event wins; a simultaneous new event takes its place.
    if (state_q == IDLE) begin
      if (hold_vld_q) begin
        ev_take_s = 1'b1;
        ev_reg_s  = hold_reg_q;
        ev_data_s = hold_data_q;
        if (we_fall_s) begin
          hold_reg_d  = bus.M68K_ADDR;
          hold_data_d = bus.M68K_DATA_IN;
        end else begin
          hold_vld_d = 1'b0;
        end
      end else if (we_fall_s) begin
        ev_take_s = 1'b1;
        ev_reg_s  = bus.M68K_ADDR;
        ev_data_s = bus.M68K_DATA_IN;
      end else begin
        ev_take_s = 1'b0;
      end
    end else if (we_fall_s) begin
      if (!hold_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_reg_d  = bus.M68K_ADDR;
        hold_data_d = bus.M68K_DATA_IN;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      IDLE: begin
        if (ev_take_s) begin
          case (ev_reg_s)
            2'd0: begin
              addr_d  = ev_data_s;
              state_d = RD_WAIT;
            end
            2'd1: begin
              wbuf_d  = ev_data_s;
              state_d = WR_WAIT;
            end
            2'd2: mod_d = ev_data_s;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (bus.CPU_SLOT) state_d = WR_DO;
        else              state_d = WR_WAIT;
      end
      WR_DO: state_d = INC;
      INC: begin
        // Only the low 15 bits step; bit 15 selects the VRAM half and is kept.
        addr_d  = {addr_q[15], addr_inc_s};
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.CPU_SLOT) state_d = RD_DO;
        else              state_d = RD_WAIT;
      end
      RD_DO: state_d = RD_CAP;
      RD_CAP: begin
        rbuf_d  = bus.VRAM_RDATA;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registers and registered outputs.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      we_sync_q   <= {SYNC_STAGES{1'b1}};
      oe_sync_q   <= {SYNC_STAGES{1'b1}};
      we_hist_q   <= 1'b1;
      oe_hist_q   <= 1'b1;
      addr_q      <= 16'h0000;
      mod_q       <= VRAMMOD_RESET;
      wbuf_q      <= 16'h0000;
      rbuf_q      <= 16'h0000;
      hold_vld_q  <= 1'b0;
      hold_reg_q  <= 2'd0;
      hold_data_q <= 16'h0000;
      overrun_q   <= 1'b0;
      vram_we_q   <= 1'b0;
      vram_re_q   <= 1'b0;
      busy_q      <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_sync_q   <= we_sync_d;
      oe_sync_q   <= oe_sync_d;
      we_hist_q   <= we_sync_q[SYNC_STAGES-1];
      oe_hist_q   <= oe_sync_q[SYNC_STAGES-1];
      addr_q      <= addr_d;
      mod_q       <= mod_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      hold_vld_q  <= hold_vld_d;
      hold_reg_q  <= hold_reg_d;
      hold_data_q <= hold_data_d;
      overrun_q   <= overrun_d;
      // Strobes are decoded from the next state so they line up with it.
      vram_we_q   <= (state_d == WR_DO);
      vram_re_q   <= (state_d == RD_DO);
      busy_q      <= (state_d != IDLE) | hold_vld_d;
      // Same timing as ANDing the last sync stages of the current cycle.
      data_oe_q   <= ~oe_sync_d[SYNC_STAGES-1] & we_sync_d[SYNC_STAGES-1];
    end
  end

  // Register read mux follows M68K_ADDR directly.
  always_comb begin
    data_out_s = 16'h0000;
    case (bus.M68K_ADDR)
      2'd0, 2'd1: data_out_s = rbuf_q;
      2'd2:       data_out_s = mod_q;
      default:    data_out_s = 16'h0000;
    endcase
  end

  assign bus.M68K_DATA_OUT = data_out_s;
  assign bus.M68K_DATA_OE  = data_oe_q;
  assign bus.VRAM_ADDR     = addr_q;
  assign bus.VRAM_WDATA    = wbuf_q;
  assign bus.VRAM_WE       = vram_we_q;
  assign bus.VRAM_RE       = vram_re_q;
  assign bus.BUSY          = busy_q;
  assign bus.OVERRUN       = overrun_q;

endmodule

// File: tb/tb_vram_cpu_port.sv
// ---------------------------------------------------------------------------
// tb_vram_cpu_port
// Directed scenarios plus a randomized phase for vram_cpu_port. A VRAM
// responder returns read data one cycle after VRAM_RE and logs every access;
// a register-level model predicts the access sequence and buffer contents.
// ---------------------------------------------------------------------------
module tb_vram_cpu_port;

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   rand_slot = 1'b0;

  acc_t obs_q[$];
  acc_t exp_q[$];
  logic [15:0] vmem [bit [15:0]];
  logic [15:0] mmem [bit [15:0]];

  // Reference model state
  logic [15:0] m_addr, m_mod, m_rbuf;

  vram_cpu_port_if bus ();

  vram_cpu_port #(
    .VRAMMOD_RESET (16'h0001),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK_24M (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bg_data(input logic [15:0] a);
    return (a == 16'h0100) ? 16'h5A5A : (a ^ 16'h3C3C);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // VRAM responder and access logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && (bus.VRAM_WE || bus.VRAM_RE)) begin
      chk("we_re_exclusive", 64'(bus.VRAM_WE & bus.VRAM_RE), 64'd0);
      if (bus.VRAM_WE) begin
        vmem[bus.VRAM_ADDR] = bus.VRAM_WDATA;
        obs_q.push_back('{1'b1, bus.VRAM_ADDR, bus.VRAM_WDATA});
      end else begin
        bus.VRAM_RDATA = vmem.exists(bus.VRAM_ADDR) ? vmem[bus.VRAM_ADDR]
                                                    : bg_data(bus.VRAM_ADDR);
        obs_q.push_back('{1'b0, bus.VRAM_ADDR, bus.VRAM_RDATA});
      end
    end
  end

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return mmem.exists(a) ? mmem[a] : bg_data(a);
  endfunction

  // Register-level behaviour of one accepted CPU write event.
  task automatic model_event(input logic [1:0] r, input logic [15:0] d);
    case (r)
      2'd0: begin
        m_addr = d;
        m_rbuf = model_rd(m_addr);
        exp_q.push_back('{1'b0, m_addr, m_rbuf});
      end
      2'd1: begin
        exp_q.push_back('{1'b1, m_addr, d});
        mmem[m_addr] = d;
        m_addr = {m_addr[15], 15'((m_addr & 16'h7FFF) + (m_mod & 16'h7FFF))};
        m_rbuf = model_rd(m_addr);
        exp_q.push_back('{1'b0, m_addr, m_rbuf});
      end
      2'd2: m_mod = d;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_addr = 16'h0000;
    m_mod  = 16'h0001;
    m_rbuf = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_slot) bus.CPU_SLOT = 1'($urandom_range(0, 1));
  endtask

  task automatic cpu_write(input logic [1:0] r, input logic [15:0] d, input bit lat);
    bus.M68K_ADDR    = r;
    bus.M68K_DATA_IN = d;
    bus.nLSPWE       = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (lat && i == 3) chk("latency_we_early", 64'(bus.VRAM_WE), 64'd0);
      if (lat && i == 4) chk("latency_we_on_time", 64'(bus.VRAM_WE), 64'd1);
    end
    bus.nLSPWE = 1'b1;
    repeat (3) step();
  endtask

  task automatic cpu_read(input logic [1:0] r, input logic [15:0] exp, input string tag);
    bus.M68K_ADDR = r;
    bus.nLSPOE    = 1'b0;
    repeat (3) step();
    chk({tag, "_data"}, 64'(bus.M68K_DATA_OUT), 64'(exp));
    chk({tag, "_oe"}, 64'(bus.M68K_DATA_OE), 64'd1);
    bus.nLSPOE = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.BUSY !== 1'b0; i++) step();
    chk("idle_within_budget", 64'(bus.BUSY), 64'd0);
    repeat (2) step();
  endtask

  task automatic check_accesses(input string tag);
    int n;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_access"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic [1:0] r, input logic [15:0] d, input bit lat);
    cpu_write(r, d, lat);
    model_event(r, d);
  endtask

  initial begin
    int busy_drops;
    logic [1:0]  r;
    logic [15:0] d;

    rst = 1'b1;
    bus.M68K_ADDR = 2'd0; bus.M68K_DATA_IN = 16'h0000;
    bus.nLSPWE = 1'b1; bus.nLSPOE = 1'b1; bus.CPU_SLOT = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_overrun", 64'(bus.OVERRUN), 64'd0);
    chk("rst_we_re", 64'({bus.VRAM_WE, bus.VRAM_RE}), 64'd0);
    chk("rst_oe", 64'(bus.M68K_DATA_OE), 64'd0);
    rst = 1'b0;
    step();
    cpu_read(2'd2, 16'h0001, "rst_mod");
    cpu_read(2'd0, 16'h0000, "rst_rbuf");

    // Basic write / increment / prefetch sequence
    bus.CPU_SLOT = 1'b1;
    do_write(2'd0, 16'h8123, 1'b0);
    wait_idle(50);
    do_write(2'd2, 16'h0020, 1'b0);
    do_write(2'd1, 16'hABCD, 1'b1);
    wait_idle(50);
    check_accesses("basic");
    cpu_read(2'd1, m_rbuf, "basic_rbuf");

    // Increment wraps within 15 bits, bit 15 preserved
    do_write(2'd0, 16'h7FFF, 1'b0);
    do_write(2'd2, 16'h0002, 1'b0);
    do_write(2'd1, 16'h1111, 1'b0);
    wait_idle(50);
    do_write(2'd0, 16'hFFFF, 1'b0);
    wait_idle(50);
    do_write(2'd1, 16'h2222, 1'b0);
    wait_idle(50);
    check_accesses("wrap");

    // Slot starvation then a single-cycle grant
    bus.CPU_SLOT = 1'b0;
    do_write(2'd1, 16'h1234, 1'b0);
    busy_drops = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.BUSY !== 1'b1) busy_drops++;
    end
    chk("starve_busy_held", 64'(busy_drops), 64'd0);
    chk("starve_no_strobe", 64'(obs_q.size()), 64'd0);
    bus.CPU_SLOT = 1'b1;
    step();
    bus.CPU_SLOT = 1'b0;
    repeat (10) step();
    chk("pulse_one_write", 64'(obs_q.size()), 64'd1);
    bus.CPU_SLOT = 1'b1;
    wait_idle(50);
    check_accesses("starve");

    // Overrun: pending + held + dropped
    bus.CPU_SLOT = 1'b0;
    chk("ovr_clear_before", 64'(bus.OVERRUN), 64'd0);
    do_write(2'd1, 16'h0A0A, 1'b0);
    do_write(2'd1, 16'h0B0B, 1'b0);
    cpu_write(2'd1, 16'h0C0C, 1'b0);
    chk("ovr_set", 64'(bus.OVERRUN), 64'd1);
    chk("ovr_busy", 64'(bus.BUSY), 64'd1);
    bus.CPU_SLOT = 1'b1;
    wait_idle(100);
    check_accesses("overrun");
    chk("ovr_sticky", 64'(bus.OVERRUN), 64'd1);

    // Reset in WR_WAIT aborts the write
    bus.CPU_SLOT = 1'b0;
    cpu_write(2'd1, 16'hDEAD, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.BUSY), 64'd0);
    chk("abort_overrun", 64'(bus.OVERRUN), 64'd0);
    chk("abort_we_re", 64'({bus.VRAM_WE, bus.VRAM_RE}), 64'd0);
    chk("abort_addr_wdata", 64'({bus.VRAM_ADDR, bus.VRAM_WDATA}), 64'd0);
    bus.CPU_SLOT = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    model_reset();
    repeat (20) step();
    chk("abort_no_strobe", 64'(obs_q.size()), 64'd0);
    cpu_read(2'd2, 16'h0001, "abort_mod");
    do_write(2'd0, 16'h0040, 1'b0);
    wait_idle(50);
    check_accesses("after_abort");

    // Read path through VRAMADDR
    do_write(2'd0, 16'h0100, 1'b0);
    wait_idle(50);
    check_accesses("read");
    cpu_read(2'd1, 16'h5A5A, "read_rbuf");
    cpu_read(2'd3, 16'h0000, "read_reserved");

    // Randomized traffic with random slot grants
    rand_slot = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      do_write(r, d, 1'b0);
      wait_idle(300);
      if (it % 10 == 9) begin
        check_accesses("random");
        cpu_read(2'd0, m_rbuf, "random_rbuf");
        cpu_read(2'd2, m_mod, "random_mod");
      end
    end
    rand_slot = 1'b0;
    chk("random_no_overrun", 64'(bus.OVERRUN), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
